// File: rtl/washer_pkg.sv
// Shared washer types and default timing constants (1 ms clock, counts in cycles).
package washer_pkg;

    typedef enum logic [1:0] {
        M_OFF  = 2'd0,
        M_FWD  = 2'd1,
        M_REV  = 2'd2,
        M_DEAD = 2'd3
    } motor_state_t;

    localparam int DEAD_CYCLES_DEF  = 200;
    localparam int FILL_TIMEOUT_DEF = 4096;
    localparam int CW_DEF           = 16;

endpackage

// File: rtl/guard_timer.sv
// Loadable down-counter that parks at zero; zero flag is decoded from the register.
module guard_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/washer_actuator_guard.sv
// Safety stage between reg_machine and the physical valves/motor: dead-time,
// lid interlock, fill/drain exclusion and a sticky fill-timeout fault.
module washer_actuator_guard
    import washer_pkg::*;
#(
    parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF,
    parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ctrl_fill,
    input  logic ctrl_release,
    input  logic ctrl_forward,
    input  logic ctrl_reverse,
    input  logic lid_closed,
    input  logic fault_clr,
    output logic valve_fill,
    output logic valve_drain,
    output logic motor_fwd,
    output logic motor_rev,
    output logic fault
);

    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(FILL_TIMEOUT - 1);

    motor_state_t  state;
    motor_state_t  state_next;
    logic          go_f;
    logic          go_r;
    logic          dead_load;
    logic          dead_dec;
    logic          dead_zero;
    logic [CW-1:0] fill_cnt;
    logic          fill_trip;
    logic          clr_ok;

    // Conflicting direction requests are treated as no request at all.
    assign go_f = ctrl_forward & ~ctrl_reverse & lid_closed & ~fault;
    assign go_r = ctrl_reverse & ~ctrl_forward & lid_closed & ~fault;

    always_comb begin
        state_next = state;
        dead_load  = 1'b0;
        case (state)
            M_OFF: begin
                if (go_f)      state_next = M_FWD;
                else if (go_r) state_next = M_REV;
            end
            M_FWD: begin
                if (!go_f) begin
                    state_next = M_DEAD;
                    dead_load  = 1'b1;
                end
            end
            M_REV: begin
                if (!go_r) begin
                    state_next = M_DEAD;
                    dead_load  = 1'b1;
                end
            end
            M_DEAD: begin
                if (dead_zero) begin
                    if (go_f)      state_next = M_FWD;
                    else if (go_r) state_next = M_REV;
                    else           state_next = M_OFF;
                end
            end
            default: state_next = M_OFF;
        endcase
    end

    assign dead_dec = (state == M_DEAD) && !dead_zero;

    guard_timer #(.CW(CW)) u_dead_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (dead_load),
        .load_val (DEAD_LOAD),
        .dec      (dead_dec),
        .zero     (dead_zero)
    );

    // Motor drives decode the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= M_OFF;
            motor_fwd <= 1'b0;
            motor_rev <= 1'b0;
        end else begin
            state     <= state_next;
            motor_fwd <= (state_next == M_FWD);
            motor_rev <= (state_next == M_REV);
        end
    end

    assign fill_trip = valve_fill && (fill_cnt == FILL_LAST);
    assign clr_ok    = fault_clr & ~ctrl_fill & ~ctrl_release & ~ctrl_forward & ~ctrl_reverse;

    always_ff @(posedge clk) begin
        if (rst) begin
            valve_fill  <= 1'b0;
            valve_drain <= 1'b0;
            fill_cnt    <= '0;
            fault       <= 1'b0;
        end else begin
            valve_drain <= ctrl_release;
            valve_fill  <= ctrl_fill & ~ctrl_release & ~fault & ~fill_trip;
            if (valve_fill && !fill_trip) fill_cnt <= fill_cnt + 1'b1;
            else                          fill_cnt <= '0;
            // A trip in the same cycle as a qualified clear keeps the fault set.
            if (fill_trip)   fault <= 1'b1;
            else if (clr_ok) fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_washer_actuator_guard.sv
// Directed bench for washer_actuator_guard with default timing (200 / 4096).
module tb_washer_actuator_guard;

    localparam int DEAD  = 200;
    localparam int FILLT = 4096;

    logic clk;
    logic rst;
    logic ctrl_fill;
    logic ctrl_release;
    logic ctrl_forward;
    logic ctrl_reverse;
    logic lid_closed;
    logic fault_clr;
    logic valve_fill;
    logic valve_drain;
    logic motor_fwd;
    logic motor_rev;
    logic fault;

    int checks = 0;
    int errors = 0;

    washer_actuator_guard dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_fill    (ctrl_fill),
        .ctrl_release (ctrl_release),
        .ctrl_forward (ctrl_forward),
        .ctrl_reverse (ctrl_reverse),
        .lid_closed   (lid_closed),
        .fault_clr    (fault_clr),
        .valve_fill   (valve_fill),
        .valve_drain  (valve_drain),
        .motor_fwd    (motor_fwd),
        .motor_rev    (motor_rev),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        ctrl_fill    = 1'b0;
        ctrl_release = 1'b0;
        ctrl_forward = 1'b0;
        ctrl_reverse = 1'b0;
        fault_clr    = 1'b0;
    endtask

    // Interlock monitor: exclusion properties and the motor-off gap on every fall.
    logic prev_any = 1'b0;
    logic armed    = 1'b0;
    int   off_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            armed    = 1'b0;
            off_cnt  = 0;
            prev_any = 1'b0;
        end else begin
            checks++;
            if ((motor_fwd & motor_rev) === 1'b1) begin
                errors++;
                $display("FAIL motor_excl: fwd=%b rev=%b required not both 1", motor_fwd, motor_rev);
            end
            checks++;
            if ((valve_fill & valve_drain) === 1'b1) begin
                errors++;
                $display("FAIL valve_excl: fill=%b drain=%b required not both 1", valve_fill, valve_drain);
            end
            if ((motor_fwd | motor_rev) === 1'b1) begin
                if (!prev_any && armed) begin
                    checks++;
                    if (off_cnt < DEAD) begin
                        errors++;
                        $display("FAIL dead_gap: off for %0d cycles required >= %0d", off_cnt, DEAD);
                    end
                end
                off_cnt  = 0;
                prev_any = 1'b1;
            end else begin
                if (prev_any) begin
                    armed   = 1'b1;
                    off_cnt = 1;
                end else begin
                    off_cnt++;
                end
                prev_any = 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        lid_closed = 1'b1;
        tick(2);
        checks++;
        if ({valve_fill, valve_drain, motor_fwd, motor_rev, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {valve_fill, valve_drain, motor_fwd, motor_rev, fault});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if ({valve_fill, valve_drain, motor_fwd, motor_rev, fault} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b required 00000",
                     {valve_fill, valve_drain, motor_fwd, motor_rev, fault});
        end
    endtask

    task automatic test_reset_mid_spin();
        ctrl_forward = 1'b1;
        ctrl_release = 1'b1;
        tick(1);
        checks++;
        if (motor_fwd !== 1'b1) begin
            errors++;
            $display("FAIL fwd_latency: motor_fwd=%b required 1", motor_fwd);
        end
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({valve_fill, valve_drain, motor_fwd, motor_rev, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_spin: got %b required 00000",
                     {valve_fill, valve_drain, motor_fwd, motor_rev, fault});
        end
        rst = 1'b0;
        ctrl_release = 1'b0;
        tick(1);
        checks++;
        if (motor_fwd !== 1'b1) begin
            errors++;
            $display("FAIL fwd_after_reset: motor_fwd=%b required 1", motor_fwd);
        end
    endtask

    task automatic test_direction_change();
        int cnt;
        tick(5);
        ctrl_forward = 1'b0;
        ctrl_reverse = 1'b1;
        tick(1);
        checks++;
        if (motor_fwd !== 1'b0 || motor_rev !== 1'b0) begin
            errors++;
            $display("FAIL dir_fwd_fall: fwd=%b rev=%b required 0 0", motor_fwd, motor_rev);
        end
        cnt = 0;
        while (motor_rev !== 1'b1 && cnt < 400) begin
            tick(1);
            cnt++;
        end
        checks++;
        if (cnt != DEAD) begin
            errors++;
            $display("FAIL dir_dead_time: rev rose after %0d cycles required %0d", cnt, DEAD);
        end
        ctrl_reverse = 1'b0;
        tick(DEAD + 2);
        checks++;
        if (motor_fwd !== 1'b0 || motor_rev !== 1'b0) begin
            errors++;
            $display("FAIL dir_stop: fwd=%b rev=%b required 0 0", motor_fwd, motor_rev);
        end
    endtask

    task automatic test_conflicts();
        ctrl_forward = 1'b1;
        ctrl_reverse = 1'b1;
        tick(4);
        checks++;
        if (motor_fwd !== 1'b0 || motor_rev !== 1'b0) begin
            errors++;
            $display("FAIL dir_conflict: fwd=%b rev=%b required 0 0", motor_fwd, motor_rev);
        end
        ctrl_forward = 1'b0;
        ctrl_reverse = 1'b0;
        ctrl_fill    = 1'b1;
        tick(1);
        checks++;
        if (valve_fill !== 1'b1 || valve_drain !== 1'b0) begin
            errors++;
            $display("FAIL fill_only: fill=%b drain=%b required 1 0", valve_fill, valve_drain);
        end
        ctrl_release = 1'b1;
        tick(1);
        checks++;
        if (valve_fill !== 1'b0 || valve_drain !== 1'b1) begin
            errors++;
            $display("FAIL fill_release: fill=%b drain=%b required 0 1", valve_fill, valve_drain);
        end
        idle_inputs();
        tick(1);
        checks++;
        if (valve_fill !== 1'b0 || valve_drain !== 1'b0) begin
            errors++;
            $display("FAIL valves_idle: fill=%b drain=%b required 0 0", valve_fill, valve_drain);
        end
    endtask

    task automatic test_lid();
        int cnt;
        lid_closed   = 1'b0;
        ctrl_forward = 1'b1;
        tick(3);
        checks++;
        if (motor_fwd !== 1'b0) begin
            errors++;
            $display("FAIL lid_open_block: motor_fwd=%b required 0", motor_fwd);
        end
        lid_closed = 1'b1;
        tick(1);
        checks++;
        if (motor_fwd !== 1'b1) begin
            errors++;
            $display("FAIL lid_close_start: motor_fwd=%b required 1", motor_fwd);
        end
        tick(3);
        lid_closed = 1'b0;
        tick(1);
        checks++;
        if (motor_fwd !== 1'b0) begin
            errors++;
            $display("FAIL lid_open_stop: motor_fwd=%b required 0", motor_fwd);
        end
        lid_closed = 1'b1;
        cnt = 0;
        while (motor_fwd !== 1'b1 && cnt < 400) begin
            tick(1);
            cnt++;
        end
        checks++;
        if (cnt != DEAD) begin
            errors++;
            $display("FAIL lid_dead_time: fwd resumed after %0d cycles required %0d", cnt, DEAD);
        end
        ctrl_forward = 1'b0;
        tick(DEAD + 2);
    endtask

    task automatic test_fill_timeout();
        int high;
        ctrl_fill = 1'b1;
        high = 0;
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            if (valve_fill === 1'b1) high++;
        end
        checks++;
        if (high != FILLT) begin
            errors++;
            $display("FAIL fill_high_cycles: got %0d required %0d", high, FILLT);
        end
        checks++;
        if (fault !== 1'b1 || valve_fill !== 1'b0) begin
            errors++;
            $display("FAIL fill_fault: fault=%b fill=%b required 1 0", fault, valve_fill);
        end
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(1);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL clr_ignored: fault=%b required 1", fault);
        end
        ctrl_fill    = 1'b0;
        ctrl_release = 1'b1;
        ctrl_forward = 1'b1;
        tick(2);
        checks++;
        if (valve_drain !== 1'b1 || motor_fwd !== 1'b0) begin
            errors++;
            $display("FAIL fault_gating: drain=%b fwd=%b required 1 0", valve_drain, motor_fwd);
        end
        idle_inputs();
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL clr_accepted: fault=%b required 0", fault);
        end
        ctrl_fill = 1'b1;
        tick(1);
        checks++;
        if (valve_fill !== 1'b1) begin
            errors++;
            $display("FAIL fill_after_clr: fill=%b required 1", valve_fill);
        end
        ctrl_fill = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        lid_closed = 1'b1;
        test_reset();
        test_reset_mid_spin();
        test_direction_change();
        test_conflicts();
        test_lid();
        test_fill_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
